msg_rx_frame: RTL

- Parametrised successor to the fixed 12-byte unit-message receiver.
- Sits between the UART byte receiver and the unit controllers.
- Delimits variable-length frames: SOF byte, payload, EOF byte.
- Decodes a 2-byte unit code against a table of NUM_UNITS entries and captures the block ID from the frame, not a hard-coded constant; reports framing errors, has per-unit sticky flags with explicit clear, and an inter-byte timeout.

---
 rtl/msg_rx_pkg.sv | 30 +++
 rtl/msg_unit_decode.sv | 27 ++
 rtl/msg_rx_frame.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/msg_rx_pkg.sv
// Shared types and constants for the msg_rx_frame receiver: FSM states,
// rejection codes, default framing bytes and the default unit-code table.
package msg_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        PARSE = 2'd2
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_OVFL    = 3'd1;
    localparam logic [2:0] ERR_SHORT   = 3'd2;
    localparam logic [2:0] ERR_UNKNOWN = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;
    localparam logic [2:0] ERR_CSUM    = 3'd6;

    localparam logic [7:0] SOF_DEFAULT = 8'h23;
    localparam logic [7:0] EOF_DEFAULT = 8'h0A;

    // First character lands in the high byte, matching how the code arrives on the wire.
    function automatic logic [15:0] pack_code(input logic [7:0] first, input logic [7:0] second);
        return {first, second};
    endfunction

    // Entry 0 sits in the low 16 bits, so "CU" is unit 0 and "RU" is unit 2.
    localparam logic [47:0] UNIT_CODES_DEFAULT = {pack_code("R", "U"), pack_code("E", "U"), pack_code("C", "U")};

endpackage

// File: rtl/msg_unit_decode.sv
// Combinational lookup of a 16-bit unit code in the code table; the lowest
// matching entry wins.
module msg_unit_decode
    import msg_rx_pkg::*;
#(
    parameter int                        NUM_UNITS  = 3,
    parameter logic [NUM_UNITS*16-1:0]   UNIT_CODES = UNIT_CODES_DEFAULT,
    localparam int                       UNIT_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic [15:0]       code,
    output logic              hit,
    output logic [UNIT_W-1:0] idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Scan from the top down so the lowest matching index is the one left standing.
        for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            if (UNIT_CODES[16*k +: 16] == code) begin
                hit = 1'b1;
                idx = UNIT_W'(k);
            end
        end
    end

endmodule

// File: rtl/msg_rx_frame.sv
// Variable-length SOF/payload/EOF frame receiver with unit-code decode, sticky
// per-unit flags and inter-byte timeout. Define MSG_RX_CHECKSUM_EN for an XOR checksum byte before EOF.
module msg_rx_frame
    import msg_rx_pkg::*;
#(
    parameter int                      MAX_LEN     = 16,
    parameter int                      NUM_UNITS   = 3,
    parameter logic [NUM_UNITS*16-1:0] UNIT_CODES  = UNIT_CODES_DEFAULT,
    parameter logic [7:0]              SOF_BYTE    = SOF_DEFAULT,
    parameter logic [7:0]              EOF_BYTE    = EOF_DEFAULT,
    parameter int                      TYPE_OFS    = 4,
    parameter int                      ID_OFS      = 7,
    parameter int                      TIMEOUT_CYC = 43390,
    localparam int                     UNIT_W      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                   clk_50M,
    input  logic                   rst_n,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    input  logic [NUM_UNITS-1:0]   unit_clr,
    output logic [NUM_UNITS-1:0]   unit_active,
    output logic [NUM_UNITS*8-1:0] unit_id,
    output logic                   msg_valid,
    output logic [UNIT_W-1:0]      msg_unit,
    output logic                   msg_err,
    output logic [2:0]             err_code,
    output logic                   busy
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
`ifdef MSG_RX_CHECKSUM_EN
    localparam int MIN_EOF = ID_OFS + 2;
`else
    localparam int MIN_EOF = ID_OFS + 1;
`endif
    localparam logic [IDX_W-1:0] MIN_EOF_IDX = IDX_W'(MIN_EOF);

    state_t             state, state_next;
    logic [IDX_W-1:0]   wr_idx, idx_next;
    logic [TO_W-1:0]    to_cnt, cnt_next;
    logic               restart, store;
    logic               ev_ok, ev_err;
    logic [2:0]         ev_code;
    logic [7:0]         frame_buf [MAX_LEN];
    logic               dec_hit;
    logic [UNIT_W-1:0]  dec_idx;
    logic               csum_bad;

    logic               ev_ok_p1, ev_err_p1;
    logic [2:0]         ev_code_p1;
    logic [UNIT_W-1:0]  ev_unit_p1;
    logic [7:0]         ev_id_p1;

    msg_unit_decode #(
        .NUM_UNITS  (NUM_UNITS),
        .UNIT_CODES (UNIT_CODES)
    ) u_decode (
        .code (pack_code(frame_buf[TYPE_OFS], frame_buf[TYPE_OFS+1])),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

`ifdef MSG_RX_CHECKSUM_EN
    // Running XOR of SOF..checksum; a correct checksum byte brings it back to zero.
    logic [7:0] csum;
    always_ff @(posedge clk_50M) begin
        if (restart) begin
            csum <= rx_byte;
        end else if (store && rx_byte != EOF_BYTE) begin
            csum <= csum ^ rx_byte;
        end
    end
    assign csum_bad = (csum != 8'h00);
`else
    assign csum_bad = 1'b0;
`endif

    always_comb begin
        state_next = state;
        idx_next   = wr_idx;
        cnt_next   = to_cnt;
        restart    = 1'b0;
        store      = 1'b0;
        ev_ok      = 1'b0;
        ev_err     = 1'b0;
        ev_code    = ERR_NONE;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (rx_valid && rx_byte == SOF_BYTE) begin
                    restart    = 1'b1;
                    idx_next   = IDX_W'(1);
                    state_next = RECV;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    cnt_next = '0;
                    if (rx_byte == SOF_BYTE) begin
                        restart  = 1'b1;
                        idx_next = IDX_W'(1);
                    end else if (rx_byte == EOF_BYTE) begin
                        store      = 1'b1;
                        state_next = PARSE;
                    end else if (wr_idx == LAST_IDX) begin
                        ev_err     = 1'b1;
                        ev_code    = ERR_OVFL;
                        idx_next   = '0;
                        state_next = IDLE;
                    end else begin
                        store    = 1'b1;
                        idx_next = wr_idx + IDX_W'(1);
                    end
                end else if (to_cnt == TO_LAST) begin
                    ev_err     = 1'b1;
                    ev_code    = ERR_TIMEOUT;
                    idx_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = to_cnt + TO_W'(1);
                end
            end
            PARSE: begin
                // wr_idx still points at the stored EOF, so it doubles as the frame length check.
                state_next = IDLE;
                idx_next   = '0;
                cnt_next   = '0;
                ev_err     = 1'b1;
                if (rx_valid) begin
                    ev_code = ERR_OVERRUN;
                end else if (wr_idx < MIN_EOF_IDX) begin
                    ev_code = ERR_SHORT;
                end else if (csum_bad) begin
                    ev_code = ERR_CSUM;
                end else if (!dec_hit) begin
                    ev_code = ERR_UNKNOWN;
                end else begin
                    ev_err = 1'b0;
                    ev_ok  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_idx <= '0;
            to_cnt <= '0;
        end else begin
            state  <= state_next;
            wr_idx <= idx_next;
            to_cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (restart) begin
            frame_buf[0] <= rx_byte;
        end else if (store) begin
            frame_buf[wr_idx] <= rx_byte;
        end
    end

    // Stage p1: registered parse/abort decision
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            ev_ok_p1   <= 1'b0;
            ev_err_p1  <= 1'b0;
            ev_code_p1 <= ERR_NONE;
        end else begin
            ev_ok_p1   <= ev_ok;
            ev_err_p1  <= ev_err;
            ev_code_p1 <= ev_code;
        end
    end

    always_ff @(posedge clk_50M) begin
        ev_unit_p1 <= dec_idx;
        ev_id_p1   <= frame_buf[ID_OFS];
    end

    // Stage p2: outputs and sticky unit state
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            msg_valid   <= 1'b0;
            msg_err     <= 1'b0;
            msg_unit    <= '0;
            err_code    <= ERR_NONE;
            unit_active <= '0;
            unit_id     <= '0;
        end else begin
            msg_valid <= ev_ok_p1;
            msg_err   <= ev_err_p1;
            if (ev_ok_p1) begin
                msg_unit <= ev_unit_p1;
                err_code <= ERR_NONE;
            end else if (ev_err_p1) begin
                err_code <= ev_code_p1;
            end
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (ev_ok_p1 && ev_unit_p1 == UNIT_W'(k)) begin
                    unit_active[k]    <= 1'b1;
                    unit_id[8*k +: 8] <= ev_id_p1;
                end else if (unit_clr[k]) begin
                    unit_active[k] <= 1'b0;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
